// File: rtl/conv_layer_sequencer_if.sv
// conv_layer_sequencer_if
//   Bundles every non-clock/reset signal of the convolution layer sequencer.
//   master : the sequencer side (drives control, engine operands, RAM addresses)
//   slave  : the environment side (drives start/config, engine replies, RAM data)
//   Groups: start + cfg_*            layer launch and configuration
//           busy, done               layer status
//           eng_*                    conv engine handshake and operand pair
//           act_/w_/bias_            read ports, 1-cycle read latency
//           out_we/out_addr/out_data output RAM write port
interface conv_layer_sequencer_if #(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned DIM_W  = 9
);
   logic                start;
   logic [DIM_W-1:0]    cfg_in_w;
   logic [DIM_W-1:0]    cfg_in_h;
   logic [10:0]         cfg_in_ch;
   logic [10:0]         cfg_out_ch;
   logic                cfg_k3;
   logic                cfg_stride2;
   logic [15:0]         cfg_scale;

   logic                busy;
   logic                done;

   logic                eng_start;
   logic [10:0]         eng_macs_count;
   logic [31:0]         eng_bias;
   logic [15:0]         eng_scale;
   logic [10:0]         eng_mac_index;
   logic signed [7:0]   eng_act;
   logic signed [7:0]   eng_w;
   logic                eng_done;
   logic [7:0]          eng_result;

   logic [ADDR_W-1:0]   act_addr;
   logic [7:0]          act_rdata;
   logic [ADDR_W-1:0]   w_addr;
   logic [7:0]          w_rdata;
   logic [10:0]         bias_addr;
   logic [31:0]         bias_rdata;

   logic                out_we;
   logic [ADDR_W-1:0]   out_addr;
   logic [7:0]          out_data;

   modport master (
      input  start, cfg_in_w, cfg_in_h, cfg_in_ch, cfg_out_ch, cfg_k3, cfg_stride2, cfg_scale,
      output busy, done,
      output eng_start, eng_macs_count, eng_bias, eng_scale, eng_act, eng_w,
      input  eng_mac_index, eng_done, eng_result,
      output act_addr, w_addr, bias_addr,
      input  act_rdata, w_rdata, bias_rdata,
      output out_we, out_addr, out_data
   );

   modport slave (
      output start, cfg_in_w, cfg_in_h, cfg_in_ch, cfg_out_ch, cfg_k3, cfg_stride2, cfg_scale,
      input  busy, done,
      input  eng_start, eng_macs_count, eng_bias, eng_scale, eng_act, eng_w,
      output eng_mac_index, eng_done, eng_result,
      input  act_addr, w_addr, bias_addr,
      output act_rdata, w_rdata, bias_rdata,
      input  out_we, out_addr, out_data
   );
endinterface

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer
//   Walks one convolution layer (oy, ox, oc outermost to innermost), feeding a
//   conv engine one output pixel/channel at a time and writing each int8 result
//   to the output RAM in increasing address order.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    conv_layer_sequencer_if.master: start/config, busy/done, engine
//            handshake + operand pair, activation/weight/bias read ports,
//            output write port
//   Operands are addressed combinationally from eng_mac_index; the RAM data
//   returns one cycle later, so eng_act/eng_w are valid the cycle after an
//   index change.
module conv_layer_sequencer #(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned DIM_W  = 9
) (
   input  logic                   clk,
   input  logic                   rst_n,
   conv_layer_sequencer_if.master bus
);

   localparam int unsigned CW = DIM_W + 3;   // signed input-coordinate width

   typedef enum logic [2:0] {
      IDLE, BIAS_RD, BIAS_LAT, ENG_START, ENG_WAIT, WRITE, ADVANCE, DONE
   } state_t;

   state_t              state_q, state_d;

   logic [DIM_W-1:0]    in_w_q, in_w_d;
   logic [DIM_W-1:0]    in_h_q, in_h_d;
   logic [10:0]         in_ch_q, in_ch_d;
   logic [10:0]         out_ch_q, out_ch_d;
   logic                k3_q, k3_d;
   logic                s2_q, s2_d;
   logic [15:0]         scale_q, scale_d;
   logic [10:0]         macs_q, macs_d;
   logic [DIM_W-1:0]    out_w_q, out_w_d;
   logic [DIM_W-1:0]    out_h_q, out_h_d;

   logic [DIM_W-1:0]    oy_q, oy_d;
   logic [DIM_W-1:0]    ox_q, ox_d;
   logic [10:0]         oc_q, oc_d;
   logic [ADDR_W-1:0]   w_base_q, w_base_d;
   logic [ADDR_W-1:0]   out_cnt_q, out_cnt_d;

   logic [31:0]         bias_q, bias_d;
   logic [7:0]          result_q, result_d;
   logic                op_valid_q, op_valid_d;
   logic                pad_q, pad_d;

   logic                op_active;
   logic [10:0]         op_idx;
   logic [14:0]         thr [16];
   logic [3:0]          kpos;
   logic [10:0]         ic;
   logic [1:0]          ky, kx;
   logic [CW-1:0]       y_base, x_base, iy, ix;
   logic [ADDR_W-1:0]   act_lin;
   logic [ADDR_W-1:0]   act_addr_c;
   logic [ADDR_W-1:0]   w_addr_c;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         in_w_q     <= '0;
         in_h_q     <= '0;
         in_ch_q    <= '0;
         out_ch_q   <= '0;
         k3_q       <= 1'b0;
         s2_q       <= 1'b0;
         scale_q    <= '0;
         macs_q     <= '0;
         out_w_q    <= '0;
         out_h_q    <= '0;
         oy_q       <= '0;
         ox_q       <= '0;
         oc_q       <= '0;
         w_base_q   <= '0;
         out_cnt_q  <= '0;
         bias_q     <= '0;
         result_q   <= '0;
         op_valid_q <= 1'b0;
         pad_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_w_q     <= in_w_d;
         in_h_q     <= in_h_d;
         in_ch_q    <= in_ch_d;
         out_ch_q   <= out_ch_d;
         k3_q       <= k3_d;
         s2_q       <= s2_d;
         scale_q    <= scale_d;
         macs_q     <= macs_d;
         out_w_q    <= out_w_d;
         out_h_q    <= out_h_d;
         oy_q       <= oy_d;
         ox_q       <= ox_d;
         oc_q       <= oc_d;
         w_base_q   <= w_base_d;
         out_cnt_q  <= out_cnt_d;
         bias_q     <= bias_d;
         result_q   <= result_d;
         op_valid_q <= op_valid_d;
         pad_q      <= pad_d;
      end
   end

   // ------------------------------------------------- next state / counters
   always_comb begin
      state_d   = state_q;
      in_w_d    = in_w_q;
      in_h_d    = in_h_q;
      in_ch_d   = in_ch_q;
      out_ch_d  = out_ch_q;
      k3_d      = k3_q;
      s2_d      = s2_q;
      scale_d   = scale_q;
      macs_d    = macs_q;
      out_w_d   = out_w_q;
      out_h_d   = out_h_q;
      oy_d      = oy_q;
      ox_d      = ox_q;
      oc_d      = oc_q;
      w_base_d  = w_base_q;
      out_cnt_d = out_cnt_q;
      bias_d    = bias_q;
      result_d  = result_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               in_w_d    = bus.cfg_in_w;
               in_h_d    = bus.cfg_in_h;
               in_ch_d   = bus.cfg_in_ch;
               out_ch_d  = bus.cfg_out_ch;
               k3_d      = bus.cfg_k3;
               s2_d      = bus.cfg_stride2;
               scale_d   = bus.cfg_scale;
               macs_d    = bus.cfg_k3 ?
                           11'(({3'b000, bus.cfg_in_ch} << 3) + {3'b000, bus.cfg_in_ch}) :
                           bus.cfg_in_ch;
               out_w_d   = bus.cfg_stride2 ? (bus.cfg_in_w >> 1) : bus.cfg_in_w;
               out_h_d   = bus.cfg_stride2 ? (bus.cfg_in_h >> 1) : bus.cfg_in_h;
               oy_d      = '0;
               ox_d      = '0;
               oc_d      = '0;
               w_base_d  = '0;
               out_cnt_d = '0;
               state_d   = BIAS_RD;
            end
         end
         BIAS_RD:   state_d = BIAS_LAT;
         BIAS_LAT: begin
            bias_d  = bus.bias_rdata;
            state_d = ENG_START;
         end
         ENG_START: state_d = ENG_WAIT;
         ENG_WAIT: begin
            if (bus.eng_done) begin
               result_d = bus.eng_result;
               state_d  = WRITE;
            end
         end
         WRITE:     state_d = ADVANCE;
         ADVANCE: begin
            // Output order equals address order, so the write address is a plain counter.
            out_cnt_d = out_cnt_q + ADDR_W'(1);
            state_d   = BIAS_RD;
            if (oc_q == out_ch_q - 11'd1) begin
               oc_d     = '0;
               w_base_d = '0;
               if (ox_q == out_w_q - DIM_W'(1)) begin
                  ox_d = '0;
                  if (oy_q == out_h_q - DIM_W'(1)) begin
                     state_d = DONE;
                  end else begin
                     oy_d = oy_q + DIM_W'(1);
                  end
               end else begin
                  ox_d = ox_q + DIM_W'(1);
               end
            end else begin
               oc_d     = oc_q + 11'd1;
               w_base_d = w_base_q + ADDR_W'(macs_q);
            end
         end
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // ------------------------------------------------- operand addressing
   always_comb begin
      op_active = (state_q == ENG_START) || (state_q == ENG_WAIT);
      op_idx    = (state_q == ENG_START) ? '0 : bus.eng_mac_index;

      // Split mac_index into kernel position and ic by comparing against the
      // multiples of in_ch instead of dividing.
      for (int unsigned k = 0; k < 16; k++) begin
         thr[k] = 15'(k) * {4'b0000, in_ch_q};
      end
      kpos = '0;
      if (k3_q) begin
         for (int unsigned k = 1; k < 9; k++) begin
            if ({4'b0000, op_idx} >= thr[k]) kpos = kpos + 4'd1;
         end
      end
      ic = 11'({4'b0000, op_idx} - thr[kpos]);

      case (kpos)
         4'd0:    begin ky = 2'd0; kx = 2'd0; end
         4'd1:    begin ky = 2'd0; kx = 2'd1; end
         4'd2:    begin ky = 2'd0; kx = 2'd2; end
         4'd3:    begin ky = 2'd1; kx = 2'd0; end
         4'd4:    begin ky = 2'd1; kx = 2'd1; end
         4'd5:    begin ky = 2'd1; kx = 2'd2; end
         4'd6:    begin ky = 2'd2; kx = 2'd0; end
         4'd7:    begin ky = 2'd2; kx = 2'd1; end
         default: begin ky = 2'd2; kx = 2'd2; end
      endcase

      y_base = s2_q ? {2'b00, oy_q, 1'b0} : {3'b000, oy_q};
      x_base = s2_q ? {2'b00, ox_q, 1'b0} : {3'b000, ox_q};
      iy     = y_base + CW'(ky) - CW'(k3_q);
      ix     = x_base + CW'(kx) - CW'(k3_q);

      // A coordinate of -1 wraps to a huge unsigned value, so one unsigned
      // compare covers both the low and the high edge.
      pad_d = (iy >= {3'b000, in_h_q}) || (ix >= {3'b000, in_w_q});

      act_lin    = (ADDR_W'(iy) * ADDR_W'(in_w_q) + ADDR_W'(ix)) * ADDR_W'(in_ch_q) + ADDR_W'(ic);
      act_addr_c = (op_active && !pad_d) ? act_lin : '0;
      w_addr_c   = op_active ? (w_base_q + ADDR_W'(op_idx)) : '0;
      op_valid_d = op_active;
   end

   // ------------------------------------------------- outputs
   assign bus.busy           = (state_q != IDLE);
   assign bus.done           = (state_q == DONE);
   assign bus.eng_start      = (state_q == ENG_START);
   assign bus.eng_macs_count = macs_q;
   assign bus.eng_bias       = bias_q;
   assign bus.eng_scale      = scale_q;
   assign bus.eng_act        = (op_valid_q && !pad_q) ? bus.act_rdata : '0;
   assign bus.eng_w          = op_valid_q ? bus.w_rdata : '0;
   assign bus.act_addr       = act_addr_c;
   assign bus.w_addr         = w_addr_c;
   assign bus.bias_addr      = (state_q == BIAS_RD) ? oc_q : '0;
   assign bus.out_we         = (state_q == WRITE);
   assign bus.out_addr       = (state_q == WRITE) ? out_cnt_q : '0;
   assign bus.out_data       = (state_q == WRITE) ? result_q : '0;

endmodule

// File: doc/conv_layer_sequencer.md
CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 Parameters: ADDR_W, default 20, width of every memory address; DIM_W, default 9, width of image height/width fields.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse that launches one layer; ignored while busy.
REQ-005 cfg_in_w, cfg_in_h  input  DIM_W each  input feature-map width and height.
REQ-006 cfg_in_ch, cfg_out_ch  input  11 each  input and output channel counts (1..1152/9 and 1..2047).
REQ-007 cfg_k3  input  1  1 = 3x3 kernel with pad 1; 0 = 1x1 kernel with no padding.
REQ-008 cfg_stride2  input  1  1 = stride 2; 0 = stride 1.
REQ-009 cfg_scale  input  16  requantize scale, passed through to the engine.
REQ-010 busy  output  1  high from the cycle after an accepted start until done.
REQ-011 done  output  1  one-cycle pulse after the last output write.
REQ-012 eng_start  output  1  one-cycle start pulse to the conv engine.
REQ-013 eng_macs_count  output  11  MACs per output pixel.
REQ-014 eng_bias  output  32  bias for the current output channel.
REQ-015 eng_scale  output  16  equals cfg_scale.
REQ-016 eng_mac_index  input  11  operand pair index requested by the engine.
REQ-017 eng_act, eng_w  output  8 each, signed  operand pair for eng_mac_index.
REQ-018 eng_done, eng_result  input  1 / 8  engine completion pulse and its int8 result.
REQ-019 act_addr, act_rdata  output ADDR_W / input 8  activation RAM port; 1-cycle read latency.
REQ-020 w_addr, w_rdata  output ADDR_W / input 8  weight RAM port; 1-cycle read latency.
REQ-021 bias_addr, bias_rdata  output 11 / input 32  bias RAM port; 1-cycle read latency.
REQ-022 out_we, out_addr, out_data  output 1 / ADDR_W / 8  output RAM write port.

Function
REQ-023 Configuration is latched on the accepted start; changes to cfg_* while busy have no effect.
REQ-024 macs = cfg_k3 ? 9*in_ch : in_ch.
REQ-025 out_w = cfg_stride2 ? in_w>>1 : in_w, and out_h likewise; an odd in_w truncates.
REQ-026 Loop order, outermost to innermost: oy, ox, oc; oc runs 0..out_ch-1 for every pixel.
REQ-027 MAC ordering: mac_index = (ky*3+kx)*in_ch + ic for 3x3 and mac_index = ic for 1x1, where ic is innermost.
REQ-028 Input coordinates: s = 1 + stride2; iy = oy*s + ky - cfg_k3 and ix = ox*s + kx - cfg_k3, both signed.
REQ-029 Activation layout is HWC: act_addr = (iy*in_w + ix)*in_ch + ic.
REQ-030 Weight address: w_addr = oc*macs + mac_index.
REQ-031 Output address: out_addr = (oy*out_w + ox)*out_ch + oc.
REQ-032 Padding: when iy or ix lies outside 0..dim-1, eng_act = 0 on the data cycle and act_addr is driven to 0.
REQ-033 eng_act and eng_w become valid on the cycle after eng_mac_index changes, and stay stable until the next change.
REQ-034 The pad flag is delayed one cycle so it aligns with act_rdata.
REQ-035 FSM states: IDLE, BIAS_RD, BIAS_LAT, ENG_START, ENG_WAIT, WRITE, ADVANCE, DONE.
REQ-036 IDLE -> BIAS_RD on start.
REQ-037 BIAS_RD drives bias_addr = oc; BIAS_LAT registers eng_bias.
REQ-038 ENG_START pulses eng_start for one cycle and presents index-0 operand addresses so data is ready.
REQ-039 ENG_WAIT -> WRITE on eng_done.
REQ-040 WRITE asserts out_we for exactly one cycle with out_data = eng_result.
REQ-041 ADVANCE increments oc, wrapping it into ox and then oy, and returns to BIAS_RD, or goes to DONE after the last pixel.
REQ-042 DONE pulses done and returns to IDLE.
REQ-043 Exactly out_h*out_w*out_ch writes occur per layer, each address written once, in increasing address order.
REQ-044 eng_done seen outside ENG_WAIT is ignored.
REQ-045 A start arriving in the same cycle as done is ignored.
REQ-046 Address arithmetic is unsigned and ADDR_W wide; any overflow is a configuration error and is not checked.

Reset
REQ-047 When rst_n is low: state = IDLE; busy, done, eng_start and out_we = 0; all addresses, eng_act, eng_w and eng_bias = 0; all counters = 0.
REQ-048 Reset asserted mid-layer aborts the layer immediately, with no further writes; the next start begins at oy = ox = oc = 0.

Verification
REQ-049 1x1, in 2x2x3, out_ch 2, stride 1 -> eng_macs_count = 3; 8 writes to addresses 0..7; results match the golden model.
REQ-050 3x3, in 4x4x1, stride 1, pixel (0,0) -> mac_index 0, 1, 2, 3 and 6 give eng_act = 0 (padding); the other 4 indices read act_addr 0, 1, 4, 5.
REQ-051 3x3, in 4x4x2, stride 2 -> out 2x2, 18 MACs per pixel; pixel (1,1) with ky = kx = 0 reads act_addr (1*4+1)*2 + ic.
REQ-052 oc = 5 with macs = 27 -> w_addr = 135 + mac_index; bias_addr = 5 before eng_start.
REQ-053 rst_n pulsed low during the third engine run -> all outputs go to 0 immediately; a fresh start reproduces a complete, correct layer.
REQ-054 start held high for 10 cycles, plus a stray eng_done in IDLE -> exactly one layer runs; no extra writes.
